// File: rtl/sn_counter.sv
// sn_counter: stochastic-number to binary converter.
//   Accumulates (P - N) of the generator's bitstream pair over a programmed
//   window of enabled cycles and offers the signed result with a valid/ack
//   handshake.
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   EN                stream advance, shared with the generator LFSR
//   DATA_IN, LEN_WE   window length load (DATA_IN[30:0])
//   START             one-cycle pulse, begins a conversion when idle
//   SN_IN_P, SN_IN_N  positive / negative bitstreams
//   BUSY              conversion in progress (SKIP or RUN)
//   RESULT            signed P-N count of the last completed window
//   RESULT_VALID      RESULT holds an unread completed result
//   RESULT_ACK        consumer read RESULT; clears RESULT_VALID
module sn_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SKIP  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [31:0]      DATA_IN,
  input  logic             LEN_WE,
  input  logic             START,
  input  logic             SN_IN_P,
  input  logic             SN_IN_N,
  output logic             BUSY,
  output logic [CNT_W-1:0] RESULT,
  output logic             RESULT_VALID,
  input  logic             RESULT_ACK
);

  localparam int unsigned LEN_W  = 31;
  localparam int unsigned SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [LEN_W-1:0]        len, len_d;
  logic [LEN_W-1:0]        remain, remain_d;
  logic [SKIP_W-1:0]       skip_cnt, skip_d;
  logic signed [CNT_W-1:0] acc, acc_d;
  logic signed [CNT_W-1:0] acc_step_c;
  logic [CNT_W-1:0]        result_d;
  logic                    valid_d;
  logic                    busy_d;
  logic                    up_c, dn_c;
  logic                    unused_data_msb;

  // Bit 31 of the length source carries no meaning.
  assign unused_data_msb = DATA_IN[31];

  // Decoded contribution of the current bit pair; 11 and 00 cancel.
  assign up_c = SN_IN_P & ~SN_IN_N;
  assign dn_c = SN_IN_N & ~SN_IN_P;

  // Saturating accumulate; only reachable when CNT_W is narrower than LEN.
  always_comb begin
    acc_step_c = acc;
    if (up_c && (acc != ACC_MAX)) begin
      acc_step_c = acc + CNT_W'(1);
    end else if (dn_c && (acc != ACC_MIN)) begin
      acc_step_c = acc - CNT_W'(1);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state;
    len_d    = len;
    remain_d = remain;
    skip_d   = skip_cnt;
    acc_d    = acc;
    result_d = RESULT;
    valid_d  = RESULT_VALID;

    if (RESULT_ACK) begin
      valid_d = 1'b0;
    end

    // Length may be reprogrammed at any time; it only affects the next START.
    if (LEN_WE) begin
      len_d = DATA_IN[LEN_W-1:0];
    end

    unique case (state)
      ST_IDLE: begin
        if (START) begin
          acc_d    = '0;
          remain_d = len;
          skip_d   = SKIP_W'(SKIP);
          valid_d  = 1'b0;
          if (len == '0) begin
            // Empty window completes immediately with a zero result.
            result_d = '0;
            valid_d  = 1'b1;
          end else if (SKIP == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_SKIP;
          end
        end
      end

      ST_SKIP: begin
        if (EN) begin
          skip_d = skip_cnt - SKIP_W'(1);
          if (skip_cnt <= SKIP_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (EN) begin
          acc_d    = acc_step_c;
          remain_d = remain - LEN_W'(1);
          // Last bit of the window: publish including this cycle's bit.
          if (remain == LEN_W'(1)) begin
            result_d = acc_step_c;
            valid_d  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      len          <= '0;
      remain       <= '0;
      skip_cnt     <= '0;
      acc          <= '0;
      BUSY         <= 1'b0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
    end else begin
      state        <= state_d;
      len          <= len_d;
      remain       <= remain_d;
      skip_cnt     <= skip_d;
      acc          <= acc_d;
      BUSY         <= busy_d;
      RESULT       <= result_d;
      RESULT_VALID <= valid_d;
    end
  end

endmodule

// File: tb/tb_sn_counter.sv
// Directed bench for sn_counter (CNT_W=32, SKIP=1).
module tb_sn_counter;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [31:0] DATA_IN;
  logic        LEN_WE;
  logic        START;
  logic        SN_IN_P;
  logic        SN_IN_N;
  logic        BUSY;
  logic [31:0] RESULT;
  logic        RESULT_VALID;
  logic        RESULT_ACK;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt;

  sn_counter #(.CNT_W(32), .SKIP(1)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .DATA_IN      (DATA_IN),
    .LEN_WE       (LEN_WE),
    .START        (START),
    .SN_IN_P      (SN_IN_P),
    .SN_IN_N      (SN_IN_N),
    .BUSY         (BUSY),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .RESULT_ACK   (RESULT_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; sampling point is 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_len(input logic [31:0] v);
    DATA_IN = v;
    LEN_WE  = 1'b1;
    tick();
    LEN_WE  = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; DATA_IN = '0; LEN_WE = 1'b0; START = 1'b0;
    SN_IN_P = 1'b0; SN_IN_N = 1'b0; RESULT_ACK = 1'b0;
    repeat (2) tick();
    check("rst_busy",   32'(BUSY), 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_valid",  32'(RESULT_VALID), 32'd0);
    RST = 1'b0;
    tick();

    // LEN=8, all +1: valid after 1 skip + 8 counted cycles.
    load_len(32'd8);
    EN = 1'b1; SN_IN_P = 1'b1; SN_IN_N = 1'b0;
    pulse_start();
    check("t2_busy_start", 32'(BUSY), 32'd1);
    repeat (8) tick();
    check("t2_valid_early", 32'(RESULT_VALID), 32'd0);
    check("t2_busy_early",  32'(BUSY), 32'd1);
    tick();
    check("t2_valid", 32'(RESULT_VALID), 32'd1);
    check("t2_result", RESULT, 32'd8);
    check("t2_busy_done", 32'(BUSY), 32'd0);

    // LEN=16, pattern 10,01,11,00 cancels to zero.
    load_len(32'd16);
    pulse_start();
    check("t3_valid_clr", 32'(RESULT_VALID), 32'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: begin SN_IN_P = 1'b1; SN_IN_N = 1'b0; end
        1: begin SN_IN_P = 1'b0; SN_IN_N = 1'b1; end
        2: begin SN_IN_P = 1'b1; SN_IN_N = 1'b1; end
        default: begin SN_IN_P = 1'b0; SN_IN_N = 1'b0; end
      endcase
      tick();
    end
    check("t3a_valid", 32'(RESULT_VALID), 32'd1);
    check("t3a_result", RESULT, 32'd0);

    // All N: -16.
    pulse_start();
    tick();
    SN_IN_P = 1'b0; SN_IN_N = 1'b1;
    repeat (15) tick();
    check("t3b_valid_early", 32'(RESULT_VALID), 32'd0);
    tick();
    check("t3b_valid", 32'(RESULT_VALID), 32'd1);
    check("t3b_result", RESULT, 32'hFFFF_FFF0);

    // LEN=10 with EN 1,0,0 repeating; stalled cycles present -1 bits that must not count.
    load_len(32'd10);
    EN = 1'b1;
    pulse_start();
    en_cnt = 0;
    for (int k = 0; k < 33; k++) begin
      EN = ((k % 3) == 0);
      SN_IN_P = EN;
      SN_IN_N = ~EN;
      tick();
      if (EN) en_cnt++;
      check($sformatf("t4_busy_%0d", k),  32'(BUSY), (en_cnt < 11) ? 32'd1 : 32'd0);
      check($sformatf("t4_valid_%0d", k), 32'(RESULT_VALID), (en_cnt >= 11) ? 32'd1 : 32'd0);
    end
    check("t4_result", RESULT, 32'd10);

    // LEN=0: immediate zero result, never busy.
    EN = 1'b1; SN_IN_P = 1'b1; SN_IN_N = 1'b0;
    RESULT_ACK = 1'b1;
    tick();
    RESULT_ACK = 1'b0;
    check("t5_ack_clr", 32'(RESULT_VALID), 32'd0);
    load_len(32'd0);
    pulse_start();
    check("t5_valid", 32'(RESULT_VALID), 32'd1);
    check("t5_result", RESULT, 32'd0);
    check("t5_busy", 32'(BUSY), 32'd0);
    tick();
    check("t5_busy_after", 32'(BUSY), 32'd0);

    // START while busy is ignored.
    load_len(32'd4);
    pulse_start();
    tick();
    tick();
    pulse_start();
    tick();
    check("t5b_valid_early", 32'(RESULT_VALID), 32'd0);
    tick();
    check("t5b_valid", 32'(RESULT_VALID), 32'd1);
    check("t5b_result", RESULT, 32'd4);
    check("t5b_busy", 32'(BUSY), 32'd0);

    // ACK in the completion cycle loses; LEN_WE mid-run affects the next window only.
    load_len(32'd3);
    pulse_start();
    tick();
    load_len(32'd5);
    tick();
    RESULT_ACK = 1'b1;
    tick();
    check("t6_ack_same_valid", 32'(RESULT_VALID), 32'd1);
    check("t6_result", RESULT, 32'd3);
    tick();
    RESULT_ACK = 1'b0;
    check("t6_ack_later", 32'(RESULT_VALID), 32'd0);
    pulse_start();
    tick();
    repeat (4) tick();
    check("t6_len5_early", 32'(RESULT_VALID), 32'd0);
    tick();
    check("t6_len5_valid", 32'(RESULT_VALID), 32'd1);
    check("t6_len5_result", RESULT, 32'd5);

    // Async reset mid-run clears outputs without a clock edge.
    load_len(32'd8);
    pulse_start();
    tick();
    tick();
    check("t1_busy_pre", 32'(BUSY), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("t1_busy",   32'(BUSY), 32'd0);
    check("t1_result", RESULT, 32'd0);
    check("t1_valid",  32'(RESULT_VALID), 32'd0);
    RST = 1'b0;
    load_len(32'd2);
    pulse_start();
    tick();
    tick();
    check("t1_post_early", 32'(RESULT_VALID), 32'd0);
    tick();
    check("t1_post_valid", 32'(RESULT_VALID), 32'd1);
    check("t1_post_result", RESULT, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
